w_mem_read_streamer: RTL and testbench

//  Read sequencer directly upstream of the weight-memory SRAM wrapper's read port. Accepts a
//  (base, length) command, issues one row read per cycle, and captures rows after the 1-cycle

---
 rtl/w_mem_pkg.sv | 18 +
 rtl/w_stream_fifo.sv | 59 +++++
 rtl/w_mem_read_streamer.sv | 131 +++++++++++++
 tb/tb_w_mem_read_streamer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_mem_pkg.sv
// Constants and state encoding shared by the weight-memory read streamer and the SRAM wrapper.
package w_mem_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 15;
    localparam int ADDR_STRIDE = 4;
    localparam int LEN_W       = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/w_stream_fifo.sv
// Small synchronous capture FIFO; the head reads as zero while empty so outputs idle at zero.
module w_stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/w_mem_read_streamer.sv
// Issues weight-row reads for a (base, length) command and streams the captured rows out
// with valid/ready backpressure, yielding the SRAM port to weight writes.
module w_mem_read_streamer
    import w_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              mem_wr_enable,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    output logic              done,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    // Handshakes: cmd and w transfer on a cycle where valid & ready are both high at the
    // rising edge; valid never waits on ready, and w_data/w_last hold while stalled.

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              zero_len_q;
    logic              accept;
    logic              issue;
    logic              credit;
    logic              pop_last;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;

    assign accept   = cmd_valid & cmd_ready;
    // Rows in flight already own a FIFO slot, which is what makes overflow impossible.
    assign credit   = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign pop_last = w_valid & w_ready & w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                // A zero-length command passes through DRAIN so done lands two cycles after accept.
                if (accept) begin
                    next_state = (cmd_len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (issue && (remain_q == LEN_W'(1))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_last || zero_len_q) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        issue     = (state == RUN) && (remain_q != '0) && !mem_wr_enable && credit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q          <= '0;
            remain_q        <= '0;
            zero_len_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= cmd_base_addr;
                remain_q   <= cmd_len;
                zero_len_q <= (cmd_len == '0);
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_W'(ADDR_STRIDE);
                remain_q <= remain_q - LEN_W'(1);
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && (remain_q == LEN_W'(1));
        end
    end

    w_stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, rd_data}),
        .pop       (w_ready),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_enable = issue;
    assign rd_addr   = addr_q;
    assign w_valid   = ~fifo_empty;
    assign w_data    = fifo_head[DATA_W-1:0];
    assign w_last    = fifo_head[DATA_W];
    assign fsm_state = state;

endmodule

// File: tb/tb_w_mem_read_streamer.sv
// Bench for w_mem_read_streamer: SRAM model, queue-based row/address model, per-cycle compare.
module tb_w_mem_read_streamer;
    import w_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              mem_wr_enable = 1'b0;
    logic              rd_enable;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              done;
    logic              busy;
    logic [1:0]        fsm_state;

    w_mem_read_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .mem_wr_enable (mem_wr_enable),
        .rd_enable     (rd_enable),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_data        (w_data),
        .w_last        (w_last),
        .done          (done),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM model ----------------
    function automatic logic [DATA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return {~a[7:0], 2'b01, a[14:0], a[6:0]};
    endfunction

    always @(posedge clk) rd_data <= rd_enable ? row_of(rd_addr) : DATA_W'($urandom);

    // ---------------- scoreboard ----------------
    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                rd_cyc_log[$];
    logic [ADDR_W-1:0] rd_addr_log[$];
    logic              in_cmd = 1'b0;
    logic              prev_stall = 1'b0;
    int                done_due = -1;
    int                outstanding = 0;
    int                rd_cnt = 0;
    int                hs_cnt = 0;
    int                accept_cyc = 0;
    int                first_wv = -1;
    int                done_cyc = -1;

    task automatic clear_model();
        exp_q.delete();
        exp_addr_q.delete();
        in_cmd      = 1'b0;
        prev_stall  = 1'b0;
        done_due    = -1;
        outstanding = 0;
    endtask

    always @(negedge clk) begin : monitor
        logic [ADDR_W-1:0] a;
        logic [DATA_W:0]   head;
        if (reset) begin
            check("busy", busy, in_cmd);
            check("cmd_ready", cmd_ready, !in_cmd);
            check("done", done, cyc == done_due);
            check("done_vs_ready", done & cmd_ready, 1'b0);
            if (prev_stall) check("w_hold_valid", w_valid, 1'b1);
            if (rd_enable) begin
                check("rd_during_write", mem_wr_enable, 1'b0);
                check("credit", outstanding < FIFO_DEPTH, 1'b1);
                if (exp_addr_q.size() == 0) check("rd_extra", 1'b1, 1'b0);
                else check("rd_addr", rd_addr, exp_addr_q.pop_front());
                rd_cyc_log.push_back(cyc);
                rd_addr_log.push_back(rd_addr);
                rd_cnt++;
                outstanding++;
            end
            if (w_valid) begin
                if (first_wv < 0) first_wv = cyc;
                if (exp_q.size() == 0) begin
                    check("w_spurious", 1'b1, 1'b0);
                end else begin
                    head = exp_q[0];
                    check("w_data", w_data, head[DATA_W-1:0]);
                    check("w_last", w_last, head[DATA_W]);
                    if (w_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        outstanding--;
                        if (head[DATA_W]) done_due = cyc + 1;
                    end
                end
            end
            prev_stall = w_valid & !w_ready;
            if (done) begin
                done_cyc = cyc;
                in_cmd   = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i < int'(cmd_len); i++) begin
                    a = ADDR_W'(int'(cmd_base_addr) + i * ADDR_STRIDE);
                    exp_addr_q.push_back(a);
                    exp_q.push_back({(i == int'(cmd_len) - 1) ? 1'b1 : 1'b0, row_of(a)});
                end
                if (cmd_len == '0) done_due = cyc + 2;
                in_cmd     = 1'b1;
                accept_cyc = cyc;
                rd_cnt     = 0;
                hs_cnt     = 0;
                first_wv   = -1;
                rd_cyc_log.delete();
                rd_addr_log.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic rand_mode = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                w_ready       = ($urandom_range(0, 3) != 0);
                mem_wr_enable = ($urandom_range(0, 4) == 0);
            end
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_base_addr = base;
        cmd_len       = len;
        cmd_valid     = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check("cmd_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!in_cmd) break;
            n++;
            if (n > 400) begin
                check("done_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [ADDR_W-1:0] t1_addr [3] = '{15'h0040, 15'h0044, 15'h0048};
    int                t3_off  [4] = '{1, 4, 5, 6};

    initial begin
        int n;
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rd_enable", rd_enable, 1'b0);
        check("rst_rd_addr", rd_addr, '0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_w_data", w_data, '0);
        check("rst_w_last", w_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        #10;
        reset = 1'b1;

        // 1: base 0x40, len 3, free-flowing output
        w_ready = 1'b1;
        send_cmd(15'h0040, 16'd3);
        wait_done();
        check("t1_rd_cnt", rd_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", rd_addr_log[i], t1_addr[i]);
            check("t1_rd_cycle", rd_cyc_log[i], accept_cyc + 1 + i);
        end
        check("t1_first_wvalid", first_wv, accept_cyc + 3);
        check("t1_rows", hs_cnt, 3);

        // 2: len 8 with output blocked for 10 cycles
        w_ready = 1'b0;
        send_cmd(15'h1230, 16'd8);
        repeat (9) @(posedge clk);
        #1;
        check("t2_stalled_rd_cnt", rd_cnt, 4);
        w_ready = 1'b1;
        wait_done();
        check("t2_rd_cnt", rd_cnt, 8);
        check("t2_rows", hs_cnt, 8);

        // 3: weight writes on the 2nd and 3rd issue cycles
        send_cmd(15'h0100, 16'd4);
        @(posedge clk); #1; mem_wr_enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_wr_enable = 1'b0;
        wait_done();
        check("t3_rd_cnt", rd_cnt, 4);
        for (int i = 0; i < 4; i++) check("t3_rd_cycle", rd_cyc_log[i], accept_cyc + t3_off[i]);

        // 4: address wrap
        send_cmd(15'h7FFC, 16'd2);
        wait_done();
        check("t4_addr0", rd_addr_log[0], 15'h7FFC);
        check("t4_addr1", rd_addr_log[1], 15'h0000);

        // 5: zero-length command
        send_cmd(15'h0ABC, 16'd0);
        wait_done();
        check("t5_rd_cnt", rd_cnt, 0);
        check("t5_no_wvalid", first_wv, -1);
        check("t5_done_cycle", done_cyc, accept_cyc + 2);

        // 6: reset in the middle of a 6-row command
        send_cmd(15'h0200, 16'd6);
        n = 0;
        while (rd_cnt < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t6_reached_row2", rd_cnt >= 2, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_cmd_ready", cmd_ready, 1'b1);
        check("t6_rd_enable", rd_enable, 1'b0);
        check("t6_rd_addr", rd_addr, '0);
        check("t6_w_valid", w_valid, 1'b0);
        check("t6_w_data", w_data, '0);
        check("t6_w_last", w_last, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_busy", busy, 1'b0);
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        send_cmd(15'h0300, 16'd3);
        wait_done();
        check("t6_after_rows", hs_cnt, 3);

        // randomized commands with random backpressure and write stalls
        rand_mode = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send_cmd(ADDR_W'($urandom), LEN_W'($urandom_range(0, 10)));
            wait_done();
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        w_ready       = 1'b1;
        mem_wr_enable = 1'b0;
        repeat (3) @(posedge clk);
        check("model_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
